// File: rtl/fpu_dispatch_pkg.sv
// Shared definitions for the 8086 ESC to FPU dispatcher.
// ESC opcodes, capture/issue state encodings, operand limits.
package fpu_dispatch_pkg;

    localparam logic [7:0] ESC_D8 = 8'hD8;
    localparam logic [7:0] ESC_D9 = 8'hD9;
    localparam logic [7:0] ESC_DA = 8'hDA;
    localparam logic [7:0] ESC_DB = 8'hDB;
    localparam logic [7:0] ESC_DC = 8'hDC;
    localparam logic [7:0] ESC_DD = 8'hDD;
    localparam logic [7:0] ESC_DE = 8'hDE;
    localparam logic [7:0] ESC_DF = 8'hDF;

    localparam int OPERAND_WORDS_MAX = 5;

    typedef enum logic [1:0] {
        C_EMPTY,
        C_COLLECT,
        C_FULL
    } cap_state_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_EXEC,
        I_BLANK,
        I_WAIT
    } iss_state_t;

endpackage

// File: rtl/fpu_operand_size.sv
// Number of 16-bit memory operand words an ESC instruction consumes.
// Register forms (mod==11) and store/env forms take no words.
module fpu_operand_size
    import fpu_dispatch_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [7:0] modrm,
    output logic [2:0] words
);

    logic [2:0] rm_reg;

    assign rm_reg = modrm[5:3];

    always_comb begin
        words = 3'd0;
        if (modrm[7:6] != 2'b11) begin
            case (opcode)
                ESC_D8, ESC_DA: words = 3'd2;
                ESC_DC:         words = 3'd4;
                ESC_DE:         words = 3'd1;
                ESC_D9: begin
                    if (rm_reg == 3'd0)
                        words = 3'd2;
                    else if (rm_reg == 3'd5)
                        words = 3'd1;
                end
                ESC_DB: begin
                    if (rm_reg == 3'd0)
                        words = 3'd2;
                    else if (rm_reg == 3'd5)
                        words = 3'd5;
                end
                ESC_DD: begin
                    if (rm_reg == 3'd0)
                        words = 3'd4;
                end
                ESC_DF: begin
                    if (rm_reg == 3'd0)
                        words = 3'd1;
                    else if (rm_reg == 3'd4)
                        words = 3'd5;
                    else if (rm_reg == 3'd5)
                        words = 3'd4;
                end
                default: words = 3'd0;
            endcase
        end
    end

endmodule

// File: rtl/fpu_esc_dispatcher.sv
// Two-stage ESC dispatcher: capture collects opcode and operand words,
// issue drives the FPU execute/ready handshake.
module fpu_esc_dispatcher
    import fpu_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        esc_valid,
    input  logic [7:0]  esc_opcode,
    input  logic [7:0]  esc_modrm,
    output logic        esc_ready,
    input  logic        mem_word_valid,
    input  logic [15:0] mem_word,
    output logic [7:0]  fpu_opcode,
    output logic [7:0]  fpu_modrm,
    output logic        fpu_execute,
    input  logic        fpu_ready,
    output logic [79:0] fpu_data_in,
    output logic [31:0] fpu_int_data_in,
    output logic        busy,
    output logic        protocol_err
);

    cap_state_t cap_state, cap_next;
    iss_state_t iss_state, iss_next;

    logic [7:0]  cap_opcode, cap_modrm;
    logic [79:0] cap_buf;
    logic [2:0]  cap_k, cap_n;
    logic [7:0]  iss_opcode, iss_modrm;
    logic [79:0] iss_buf;
    logic        perr;

    logic [2:0] size_n;
    logic       accept, word_ok, last_word, transfer;

    fpu_operand_size u_size (
        .opcode (esc_opcode),
        .modrm  (esc_modrm),
        .words  (size_n)
    );

    assign accept    = esc_valid && (cap_state == C_EMPTY);
    assign word_ok   = mem_word_valid && (cap_state == C_COLLECT);
    assign last_word = word_ok && (cap_k == cap_n - 3'd1);
    assign transfer  = (cap_state == C_FULL) && (iss_state == I_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_state <= C_EMPTY;
            iss_state <= I_IDLE;
        end else begin
            cap_state <= cap_next;
            iss_state <= iss_next;
        end
    end

    always_comb begin
        cap_next = cap_state;
        unique case (cap_state)
            C_EMPTY: begin
                if (esc_valid)
                    cap_next = (size_n == 3'd0) ? C_FULL : C_COLLECT;
            end
            C_COLLECT: begin
                if (last_word)
                    cap_next = C_FULL;
            end
            C_FULL: begin
                if (iss_state == I_IDLE)
                    cap_next = C_EMPTY;
            end
            default: cap_next = C_EMPTY;
        endcase
    end

    // fpu_ready is deliberately ignored in I_BLANK while the FPU
    // may still be showing ready from the previous instruction.
    always_comb begin
        iss_next = iss_state;
        unique case (iss_state)
            I_IDLE: begin
                if (cap_state == C_FULL)
                    iss_next = I_EXEC;
            end
            I_EXEC:  iss_next = I_BLANK;
            I_BLANK: iss_next = I_WAIT;
            I_WAIT: begin
                if (fpu_ready)
                    iss_next = I_IDLE;
            end
            default: iss_next = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_opcode <= '0;
            cap_modrm  <= '0;
            cap_buf    <= '0;
            cap_k      <= '0;
            cap_n      <= '0;
            iss_opcode <= '0;
            iss_modrm  <= '0;
            iss_buf    <= '0;
            perr       <= 1'b0;
        end else begin
            if (accept) begin
                cap_opcode <= esc_opcode;
                cap_modrm  <= esc_modrm;
                cap_n      <= size_n;
                cap_buf    <= '0;
                cap_k      <= '0;
            end else if (word_ok) begin
                for (int w = 0; w < OPERAND_WORDS_MAX; w++) begin
                    if (cap_k == 3'(w))
                        cap_buf[w*16 +: 16] <= mem_word;
                end
                cap_k <= cap_k + 3'd1;
            end
            if (transfer) begin
                iss_opcode <= cap_opcode;
                iss_modrm  <= cap_modrm;
                iss_buf    <= cap_buf;
            end
            if (mem_word_valid && !word_ok)
                perr <= 1'b1;
        end
    end

    assign esc_ready       = (cap_state == C_EMPTY);
    assign busy            = (cap_state != C_EMPTY) || (iss_state != I_IDLE);
    assign fpu_execute     = (iss_state == I_EXEC);
    assign fpu_opcode      = iss_opcode;
    assign fpu_modrm       = iss_modrm;
    assign fpu_data_in     = iss_buf;
    assign fpu_int_data_in = iss_buf[31:0];
    assign protocol_err    = perr;

endmodule
